// File: rtl/div_clk_mon_pkg.sv
// -----------------------------------------------------------------------------
// div_clk_mon_pkg
// Shared types and defaults for the divided-clock monitor.
//   state_t        : monitor FSM encoding (IDLE, MEASURE, LOCKED, FAULT)
//   DEF_*          : default parameter values used by div_clk_monitor
//   abs_diff()     : absolute difference helper for the period tolerance test
// -----------------------------------------------------------------------------
package div_clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam int DEF_EXP_PERIOD = 4;
    localparam int DEF_TOL        = 0;
    localparam int DEF_LOCK_CNT   = 4;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_EDGE_W     = 16;

    function automatic int abs_diff(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/div_clk_monitor_sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings the asynchronous divided clock into the clk_i domain and flags its
// rising edges.
//   clk_i   in  source clock
//   rst     in  asynchronous, active-high reset
//   clk_div in  divided clock under test (asynchronous)
//   rise    out high for one clk_i cycle per accepted rising edge
// Build option: DIV_CLK_MON_GLITCH_FILTER_EN adds a filter flop s2b; a level
// is accepted only when s2 and s2b agree, adding one cycle of latency and
// rejecting single-cycle pulses.
// -----------------------------------------------------------------------------
module sync_edge_det
    import div_clk_mon_pkg::*;
(
    input  logic clk_i,
    input  logic rst,
    input  logic clk_div,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;   // history of the accepted level
    logic lvl;  // accepted (optionally filtered) level

`ifdef DIV_CLK_MON_GLITCH_FILTER_EN
    logic s2b;

    // NOTE: every flop here is cleared by the async reset so the edge detector
    // cannot see a spurious rise straight out of reset.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            s2b <= 1'b0;
            s3  <= 1'b0;
        end else begin
            s1  <= clk_div;
            s2  <= s1;
            s2b <= s2;
            s3  <= lvl;
        end
    end

    // Hold the previously accepted level until two consecutive samples agree.
    always_comb begin
        lvl = s3;
        if (s2 == s2b) begin
            lvl = s2;
        end
    end
`else
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= clk_div;
            s2 <= s1;
            s3 <= lvl;
        end
    end

    assign lvl = s2;
`endif

    assign rise = lvl & ~s3;

endmodule

// File: rtl/div_clk_monitor.sv
// -----------------------------------------------------------------------------
// div_clk_monitor
// Measures the period of a locally divided clock in clk_i cycles, declares
// lock after LOCK_CNT consecutive in-tolerance periods and raises a sticky
// fault on any later deviation or stall.
//   Parameters: EXP_PERIOD (expected period), TOL (allowed |deviation|),
//               LOCK_CNT (good periods to lock), CNT_W (period counter width),
//               EDGE_W (edge counter width)
//   clk_i      in   source clock
//   rst        in   asynchronous, active-high reset
//   clk_div    in   divided clock under test (asynchronous)
//   clr        in   synchronous clear of state, counters and fault
//   edge_pulse out  one-cycle pulse per accepted rising edge
//   period     out  most recent measured period
//   period_vld out  one-cycle strobe when period updates
//   locked     out  high while in LOCKED
//   fault      out  sticky error flag
//   edge_cnt   out  accepted edge count, wraps
// Build option: DIV_CLK_MON_GLITCH_FILTER_EN enables the glitch filter in
// sync_edge_det (one extra cycle of latency).
// -----------------------------------------------------------------------------
module div_clk_monitor
    import div_clk_mon_pkg::*;
#(
    parameter int EXP_PERIOD = DEF_EXP_PERIOD,
    parameter int TOL        = DEF_TOL,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int EDGE_W     = DEF_EDGE_W
)(
    input  logic              clk_i,
    input  logic              rst,
    input  logic              clk_div,
    input  logic              clr,
    output logic              edge_pulse,
    output logic [CNT_W-1:0]  period,
    output logic              period_vld,
    output logic              locked,
    output logic              fault,
    output logic [EDGE_W-1:0] edge_cnt
);

    localparam int GOOD_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state;
    logic [CNT_W-1:0]   per_cnt;
    logic [GOOD_W-1:0]  good_cnt;
    logic               rise;

    logic               per_sat;
    logic [CNT_W-1:0]   meas;
    logic               meas_good;
    logic               lock_reached;
    logic               stall;

    sync_edge_det u_sync (
        .clk_i   (clk_i),
        .rst     (rst),
        .clk_div (clk_div),
        .rise    (rise)
    );

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        per_sat      = 1'b0;
        meas         = per_cnt;
        meas_good    = 1'b0;
        lock_reached = 1'b0;
        stall        = 1'b0;

        per_sat = (per_cnt == CNT_MAX);
        // The edge cycle itself is part of the period, hence +1 (saturating).
        if (!per_sat) begin
            meas = per_cnt + 1'b1;
        end
        meas_good    = abs_diff(int'(meas), EXP_PERIOD) <= TOL;
        lock_reached = (int'(good_cnt) + 1) >= LOCK_CNT;
        stall        = per_sat && ((state == MEASURE) || (state == LOCKED));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this clock edge.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            per_cnt    <= '0;
            good_cnt   <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            edge_pulse <= 1'b0;
            edge_cnt   <= '0;
            locked     <= 1'b0;
            fault      <= 1'b0;
        end else if (clr) begin
            // clr outranks a same-cycle edge: the edge is simply dropped.
            state      <= IDLE;
            per_cnt    <= '0;
            good_cnt   <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            edge_pulse <= 1'b0;
            edge_cnt   <= '0;
            locked     <= 1'b0;
            fault      <= 1'b0;
        end else begin
            edge_pulse <= rise;
            period_vld <= 1'b0;
            if (!per_sat) begin
                per_cnt <= per_cnt + 1'b1;
            end

            if (rise) begin
                per_cnt  <= '0;
                edge_cnt <= edge_cnt + 1'b1;

                // No reference edge exists in IDLE, so no period is reported.
                if (state != IDLE) begin
                    period     <= meas;
                    period_vld <= 1'b1;
                end

                unique case (state)
                    IDLE: begin
                        state    <= MEASURE;
                        good_cnt <= '0;
                    end
                    MEASURE: begin
                        if (meas_good) begin
                            good_cnt <= good_cnt + 1'b1;
                            if (lock_reached) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            good_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!meas_good) begin
                            state  <= FAULT;
                            locked <= 1'b0;
                            fault  <= 1'b1;
                        end
                    end
                    FAULT: begin
                        state <= FAULT;
                    end
                endcase
            end else if (stall) begin
                // Divided clock stopped: fall back to IDLE; losing lock is a fault.
                state    <= IDLE;
                good_cnt <= '0;
                locked   <= 1'b0;
                if (state == LOCKED) begin
                    fault <= 1'b1;
                end
            end
        end
    end

endmodule
